// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a uart transmitter one frame at a time
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    input  logic              clr_ovf,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_nx;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              push, pop, drop;

    assign full     = count == FULL_CNT;
    assign empty    = count == '0;
    assign push     = wr_en && !full && !flush;
    assign drop     = wr_en && full && !flush;
    assign pop      = state == IDLE && !empty && !tx_busy && !flush;
    assign tx_start = state == LOAD;

    // Drain sequencing: pop, pulse start, then wait out one full busy cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = pop ? LOAD : IDLE;
            LOAD:    state_nx = WAIT_HI;
            WAIT_HI: state_nx = tx_busy ? WAIT_LO : WAIT_HI;
            default: state_nx = tx_busy ? WAIT_LO : IDLE;
        endcase
    end

    // Drain state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Byte storage, left unreset
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy, output byte and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_data  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                if (push != pop)
                    count <= push ? count + (ADDR_W + 1)'(1) : count - (ADDR_W + 1)'(1);
            end
            if (pop)
                tx_data <= mem[rd_ptr];
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed table-driven bench for uart_tx_fifo (DEPTH 16 and DEPTH 4)
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       wr_en16 = 1'b0, flush16 = 1'b0, clr_ovf16 = 1'b0;
    logic [7:0] wr_data16 = 8'h00;
    logic       full16, empty16, overflow16, tx_start16, tx_busy16;
    logic [4:0] count16;
    logic [7:0] tx_data16;

    logic       wr_en4 = 1'b0, flush4 = 1'b0, clr_ovf4 = 1'b0;
    logic [7:0] wr_data4 = 8'h00;
    logic       full4, empty4, overflow4, tx_start4, tx_busy4;
    logic [2:0] count4;
    logic [7:0] tx_data4;

    logic force_busy = 1'b0;
    logic mbusy16, mbusy4;
    int   bcnt16, bcnt4;
    int   cyc = 0;
    int   starts16 = 0;
    int   fall_cyc = -1000;
    int   min_gap = 1000;
    int   busy_viol = 0;
    logic [7:0] cap16[$];
    logic [7:0] cap4[$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       clr;
        logic [4:0] cnt;
        logic       f;
        logic       e;
        logic       o;
    } vec_t;
    vec_t vecs[19];

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) u16 (
        .clk(clk), .rst(rst), .wr_en(wr_en16), .wr_data(wr_data16), .flush(flush16),
        .clr_ovf(clr_ovf16), .full(full16), .empty(empty16), .count(count16),
        .overflow(overflow16), .tx_data(tx_data16), .tx_start(tx_start16), .tx_busy(tx_busy16)
    );

    uart_tx_fifo #(.DEPTH(4), .ADDR_W(2)) u4 (
        .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_data(wr_data4), .flush(flush4),
        .clr_ovf(clr_ovf4), .full(full4), .empty(empty4), .count(count4),
        .overflow(overflow4), .tx_data(tx_data4), .tx_start(tx_start4), .tx_busy(tx_busy4)
    );

    always #5 clk = ~clk;

    assign tx_busy16 = mbusy16 | force_busy;
    assign tx_busy4  = mbusy4;

    // Cycle counter used for gap measurement
    always @(posedge clk) cyc <= cyc + 1;

    // uart model for the 16-deep FIFO: busy for 20 cycles after a sampled start
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mbusy16 <= 1'b0;
            bcnt16  <= 0;
        end else begin
            if (tx_start16) begin
                starts16 <= starts16 + 1;
                cap16.push_back(tx_data16);
                if (cyc - fall_cyc < min_gap)
                    min_gap <= cyc - fall_cyc;
                if (tx_busy16)
                    busy_viol <= busy_viol + 1;
            end
            if (tx_start16 && !mbusy16) begin
                mbusy16 <= 1'b1;
                bcnt16  <= 19;
            end else if (mbusy16) begin
                if (bcnt16 == 0) begin
                    mbusy16  <= 1'b0;
                    fall_cyc <= cyc;
                end else
                    bcnt16 <= bcnt16 - 1;
            end
        end
    end

    // uart model for the 4-deep FIFO: short 2-cycle frames
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mbusy4 <= 1'b0;
            bcnt4  <= 0;
        end else begin
            if (tx_start4)
                cap4.push_back(tx_data4);
            if (tx_start4 && !mbusy4) begin
                mbusy4 <= 1'b1;
                bcnt4  <= 1;
            end else if (mbusy4) begin
                if (bcnt4 == 0)
                    mbusy4 <= 1'b0;
                else
                    bcnt4 <= bcnt4 - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int s0, base, sent, max_c4;
        logic [7:0] exp4[$];

        for (int i = 0; i < 16; i++)
            vecs[i] = '{1'b1, 8'(i + 1), 1'b0, 5'(i + 1), i == 15, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 8'hFF, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 8'hFF, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count16), 32'd0);
        chk("rst_empty", 32'(empty16), 32'd1);
        chk("rst_full", 32'(full16), 32'd0);
        chk("rst_ovf", 32'(overflow16), 32'd0);
        chk("rst_start", 32'(tx_start16), 32'd0);
        chk("rst_data", 32'(tx_data16), 32'h00);
        rst = 1'b0;

        // single byte
        @(negedge clk);
        wr_en16 = 1'b1;
        wr_data16 = 8'hA5;
        @(negedge clk);
        wr_en16 = 1'b0;
        chk("single_count_after_write", 32'(count16), 32'd1);
        chk("single_empty_after_write", 32'(empty16), 32'd0);
        chk("single_start_early", 32'(tx_start16), 32'd0);
        @(negedge clk);
        chk("single_start", 32'(tx_start16), 32'd1);
        chk("single_data", 32'(tx_data16), 32'hA5);
        chk("single_count_after_pop", 32'(count16), 32'd0);
        chk("single_empty_after_pop", 32'(empty16), 32'd1);
        @(negedge clk);
        chk("single_start_one_cycle", 32'(tx_start16), 32'd0);
        chk("single_busy", 32'(tx_busy16), 32'd1);
        for (int k = 0; k < 40 && tx_busy16; k++) @(negedge clk);
        chk("single_busy_done", 32'(tx_busy16), 32'd0);
        repeat (3) @(negedge clk);
        chk("single_start_total", 32'(starts16), 32'd1);
        chk("single_data_hold", 32'(tx_data16), 32'hA5);

        // burst fill and overflow table
        force_busy = 1'b1;
        for (int i = 0; i < 19; i++) begin
            wr_en16 = vecs[i].wr;
            wr_data16 = vecs[i].data;
            clr_ovf16 = vecs[i].clr;
            @(negedge clk);
            chk($sformatf("vec%0d_count", i), 32'(count16), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_full", i), 32'(full16), 32'(vecs[i].f));
            chk($sformatf("vec%0d_empty", i), 32'(empty16), 32'(vecs[i].e));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow16), 32'(vecs[i].o));
            chk($sformatf("vec%0d_start", i), 32'(tx_start16), 32'd0);
        end
        wr_en16 = 1'b0;
        clr_ovf16 = 1'b0;

        // drain in order
        base = cap16.size();
        s0 = starts16;
        force_busy = 1'b0;
        for (int k = 0; k < 1500 && !(starts16 - s0 == 16 && !tx_busy16); k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("burst_starts", 32'(starts16 - s0), 32'd16);
        chk("burst_captured", 32'(cap16.size() - base), 32'd16);
        for (int i = 0; i < 16 && base + i < cap16.size(); i++)
            chk($sformatf("burst_byte%0d", i), 32'(cap16[base + i]), 32'(i + 1));
        chk("burst_gap", 32'(min_gap), 32'd3);
        chk("burst_no_start_while_busy", 32'(busy_viol), 32'd0);
        chk("burst_empty", 32'(empty16), 32'd1);

        // flush during WAIT_HI with simultaneous write
        force_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_en16 = 1'b1;
            wr_data16 = 8'(8'h31 + k);
            @(negedge clk);
        end
        wr_en16 = 1'b0;
        force_busy = 1'b0;
        chk("flush_queued", 32'(count16), 32'd5);
        @(negedge clk);
        chk("flush_pop_start", 32'(tx_start16), 32'd1);
        chk("flush_pop_data", 32'(tx_data16), 32'h31);
        chk("flush_pop_count", 32'(count16), 32'd4);
        @(negedge clk);
        chk("flush_busy", 32'(tx_busy16), 32'd1);
        s0 = starts16;
        flush16 = 1'b1;
        wr_en16 = 1'b1;
        wr_data16 = 8'hEE;
        @(negedge clk);
        flush16 = 1'b0;
        wr_en16 = 1'b0;
        chk("flush_count", 32'(count16), 32'd0);
        chk("flush_empty", 32'(empty16), 32'd1);
        chk("flush_ovf", 32'(overflow16), 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_no_more_start", 32'(starts16 - s0), 32'd0);
        chk("flush_inflight_data", 32'(tx_data16), 32'h31);
        chk("flush_frame_done", 32'(tx_busy16), 32'd0);

        // asynchronous reset mid-frame
        force_busy = 1'b1;
        for (int k = 0; k < 17; k++) begin
            wr_en16 = 1'b1;
            wr_data16 = 8'(8'h50 + k);
            @(negedge clk);
        end
        wr_en16 = 1'b0;
        force_busy = 1'b0;
        chk("arst_pre_ovf", 32'(overflow16), 32'd1);
        chk("arst_pre_full", 32'(full16), 32'd1);
        @(negedge clk);
        chk("arst_pre_start", 32'(tx_start16), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_start", 32'(tx_start16), 32'd0);
        chk("arst_count", 32'(count16), 32'd0);
        chk("arst_empty", 32'(empty16), 32'd1);
        chk("arst_full", 32'(full16), 32'd0);
        chk("arst_ovf", 32'(overflow16), 32'd0);
        chk("arst_data", 32'(tx_data16), 32'h00);
        @(negedge clk);
        rst = 1'b0;

        // pointer wrap through DEPTH 4 with mixed push/pop
        sent = 0;
        max_c4 = 0;
        for (int k = 0; k < 3000 && (sent < 40 || cap4.size() < 40); k++) begin
            if (sent < 40 && !full4 && (k % 3 != 2)) begin
                wr_en4 = 1'b1;
                wr_data4 = 8'(sent * 7 + 3);
                exp4.push_back(8'(sent * 7 + 3));
                sent++;
            end else
                wr_en4 = 1'b0;
            @(negedge clk);
            if (32'(count4) > max_c4)
                max_c4 = 32'(count4);
        end
        wr_en4 = 1'b0;
        chk("wrap_captured", 32'(cap4.size()), 32'd40);
        for (int i = 0; i < 40 && i < cap4.size(); i++)
            chk($sformatf("wrap_byte%0d", i), 32'(cap4[i]), 32'(exp4[i]));
        chk("wrap_max_count_le_4", 32'(max_c4 <= 4), 32'd1);
        chk("wrap_ovf", 32'(overflow4), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO that sits directly upstream of the `uart` transmitter. The CPU (or any byte producer) pushes bytes with a single-cycle write strobe, without waiting for the serial line. A drain state machine pops one byte at a time, presents it on `tx_data`, pulses `tx_start` and waits for `tx_busy` to complete a full assert/deassert cycle before sending the next byte. Status outputs (`full`, `empty`, `count`, sticky `overflow`) are intended for memory-mapped readback.

## Interface
- `DEPTH`, default 16: number of FIFO entries; must be a power of 2 and ≥ 2.
- `ADDR_W`, default 4: pointer width; must equal log2(DEPTH).

Ports (reset is `rst`, asynchronous, active-high; clock is `clk`):
- `clk` in 1: system clock, shared with `uart`.
- `rst` in 1: asynchronous active-high reset.
- `wr_en` in 1: push strobe, sampled each rising edge.
- `wr_data` in 8: byte to push.
- `flush` in 1: discard all queued bytes.
- `clr_ovf` in 1: clear the sticky overflow flag.
- `full` out 1: high when `count == DEPTH`.
- `empty` out 1: high when `count == 0`.
- `count` out ADDR_W+1: number of queued bytes (0..DEPTH).
- `overflow` out 1: sticky; set when a write is dropped.
- `tx_data` out 8: byte to `uart`.
- `tx_start` out 1: one-cycle start pulse to `uart`.
- `tx_busy` in 1: busy flag from `uart`.

## Operation
- Storage:
  - `DEPTH`×8 register array with `wr_ptr` and `rd_ptr` (each ADDR_W bits), both wrapping modulo `DEPTH`.
  - `count` is a separate ADDR_W+1 register.
  - Array contents are not reset.
- Push:
  - Accepted when `wr_en` is high and `count < DEPTH` on the pre-edge value.
  - Writes `mem[wr_ptr]` and increments `wr_ptr`.
  - When full, a write is rejected even if a pop happens in the same cycle. The rejected write sets `overflow`.
- Pop: occurs only on the IDLE→LOAD transition. It performs `tx_data <= mem[rd_ptr]` and `rd_ptr++`.
- Count update per cycle: +1 on push only, −1 on pop only, unchanged when both occur.
- FSM (2-bit state register):
  - IDLE: if `!empty && !tx_busy`, pop and go to LOAD; otherwise stay.
  - LOAD: `tx_start = 1`; go to WAIT_HI unconditionally.
  - WAIT_HI: stay until `tx_busy == 1`, then go to WAIT_LO.
  - WAIT_LO: stay until `tx_busy == 0`, then go to IDLE.
- `tx_start` is decoded as `state == LOAD`, so it is exactly one cycle wide and glitch-free.
- `tx_data` holds its value from the pop until the next pop and is never changed mid-frame.
- Flush:
  - Sets `wr_ptr`, `rd_ptr` and `count` to 0 in one cycle.
  - Has priority over a simultaneous push (the push is dropped and `overflow` is not set) and suppresses a simultaneous pop.
  - Does not abort a byte already in LOAD, WAIT_HI or WAIT_LO; that byte finishes normally.
- Overflow flag:
  - `clr_ovf` clears `overflow`.
  - If a dropped write and `clr_ovf` occur in the same cycle, the set wins.
- Reset values:
  - state = IDLE, `tx_start` = 0, `tx_data` = 8'h00.
  - `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0.
  - Pointers = 0.
- Reset mid-frame returns to IDLE immediately and drops all queued bytes. The `uart` shares `rst`, so the line also returns to idle.

## Timing
- Push at edge N: `count`, `empty` and `full` reflect the push after edge N.
- Latency from a write into an empty, idle FIFO (write at edge N):
  - Pop at edge N+1.
  - `tx_start` high between edges N+1 and N+2.
  - `uart` latches at N+2; `tx_busy` is high after N+2.
- Inter-frame gap: `tx_busy` falls at edge M → IDLE at M+1 → LOAD at M+2 → next `tx_start` sampled at M+3. The gap is 3 clocks.
- At most one `tx_start` is issued per `tx_busy` high period; no second start can be issued while `uart` is busy.
- `full` and `empty` are combinational from `count` and have no extra register stage.

## Test plan
- **Reset:** assert `rst` mid-operation → all outputs return to reset values asynchronously; `tx_start` = 0 with no clock edge.
- **Single byte:**
  - Stimulus: write 8'hA5 into the idle FIFO, with a `tx_busy` model that asserts 1 cycle after start and holds for 20 cycles.
  - Required: `tx_start` high for exactly one cycle, 1 cycle after the write edge, with `tx_data` = 8'hA5; `count` goes 1→0 at the pop; `empty` = 1 afterwards.
- **Burst and order:**
  - Stimulus: write 8'h01..8'h10 on 16 consecutive cycles (DEPTH = 16) while `tx_busy` is held high.
  - Required: `full` = 1 and `count` = 16. After releasing busy, bytes emerge in order 01..10 with exactly 16 `tx_start` pulses, each gap ≥ 3 clocks after `tx_busy` falls.
- **Overflow:**
  - Stimulus: with the FIFO full, write 8'hFF.
  - Required: byte dropped, `count` stays 16, `overflow` = 1.
  - Then `clr_ovf` with a simultaneous dropped write → `overflow` stays 1; `clr_ovf` alone → 0.
- **Pointer wrap:** push and pop 40 bytes through DEPTH = 4 with mixed simultaneous push/pop cycles → output sequence equals input sequence and `count` never exceeds 4.
- **Flush:**
  - Stimulus: queue 5 bytes; while in WAIT_HI, assert `flush` together with `wr_en`.
  - Required: `count` = 0 next cycle, no overflow, the in-flight byte completes, and no further `tx_start` occurs.
